pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and stall sequencer for the five-stage RV32 pipeline. It drives the stall and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and selects the EX-stage operand forwarding sources. It resolves three hazard classes:
- load-use data hazards;
- control redirects from EX (taken branch or jump);
- multi-cycle data-memory waits, with a bounded timeout.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles for dmem_ready before forced release; legal range 2..255.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- rs1_id, rs2_id  in  5  ID-stage source registers
- use_rs1_id, use_rs2_id  in  1  ID instruction actually reads rs1/rs2
- rs1_ex, rs2_ex  in  5  EX-stage source registers
- rd_ex  in  5  EX destination
- mem_read_ex  in  1  EX instruction is a load
- rd_mem  in  5  MEM destination
- reg_write_mem  in  1  MEM instruction writes rd
- rd_wb  in  5  WB destination
- reg_write_wb  in  1  WB instruction writes rd
- pc_src_ex  in  1  EX branch taken or jump
- dmem_req_mem  in  1  MEM stage has an active data-memory access
- dmem_ready  in  1  data memory completes the access this cycle
- stall_if, stall_id, stall_ex, stall_mem  out  1  hold the corresponding stage register
- flush_id, flush_ex, flush_wb  out  1  bubble into IF/ID, ID/EX, MEM/WB
- forward_a, forward_b  out  2  EX operand source: 00 register file, 01 WB, 10 MEM
- mem_timeout_err  out  1  sticky; a memory wait hit MEM_TIMEOUT

## Operation
FSM states are RUN and MEM_WAIT. A wait-cycle counter `wait_cnt` is 8 bits wide.

Condition definitions:
- mem_stall = dmem_req_mem & ~dmem_ready & ~release.
- release = (state==MEM_WAIT) & (wait_cnt==MEM_TIMEOUT-1).
- load_use = mem_read_ex & (rd_ex!=0) & ((use_rs1_id & rd_ex==rs1_id) | (use_rs2_id & rd_ex==rs2_id)).

Priority, highest first; all outputs are combinational from state plus inputs:
1. mem_stall:
   - stall_if = stall_id = stall_ex = stall_mem = 1, flush_wb = 1.
   - All other flushes are 0.
   - pc_src_ex and load_use are ignored because EX does not advance.
2. pc_src_ex:
   - flush_id = flush_ex = 1, no stalls.
   - A load_use in the same cycle is discarded, since the ID instruction is squashed.
3. load_use:
   - stall_if = stall_id = 1, flush_ex = 1, for exactly one cycle.
   - The load then advances to MEM and the condition clears naturally.
4. Otherwise all stall and flush outputs are 0.

Forwarding, evaluated independently for A (rs1_ex) and B (rs2_ex):
- 10 if reg_write_mem & rd_mem!=0 & rd_mem==rsX_ex;
- else 01 if reg_write_wb & rd_wb!=0 & rd_wb==rsX_ex;
- else 00.

MEM takes precedence over WB. Forwarding stays valid during stalls.

FSM transitions:
- RUN → MEM_WAIT when mem_stall. At this transition wait_cnt ← 1.
- In MEM_WAIT, while mem_stall remains true: wait_cnt increments.
- MEM_WAIT → RUN when dmem_ready=1. That cycle has no stall.
- MEM_WAIT → RUN when release. That cycle has no stall: the access is treated as complete and mem_timeout_err ← 1.
- mem_timeout_err stays set until reset.
- A dmem_req_mem that drops in MEM_WAIT also returns the FSM to RUN.

## Timing
- Reset (reset_n=0 at a rising edge): state ← RUN, wait_cnt ← 0, mem_timeout_err ← 0.
- While reset_n=0, every stall, flush and forward output is forced to 0, overriding the inputs.
- Reset asserted mid-wait aborts the wait. The first cycle after reset is in RUN.
- Stall, flush and forward outputs have zero latency: they respond in the same cycle as the inputs.
- Only state, wait_cnt and mem_timeout_err are registered.
- Load-use bubble: exactly 1 cycle.
- Redirect: 1 cycle of flush_id and flush_ex.
- Memory wait: stalled for N cycles when dmem_ready arrives N cycles after the request (N=0 means no stall).
- Maximum stall is MEM_TIMEOUT-1 cycles; the forced-release cycle itself carries no stall.
- Back-to-back memory accesses:
  - Each access is evaluated afresh in RUN.
  - A new access presented in the release cycle restarts at wait_cnt=1 on the next cycle if it is still not ready.

## Configuration
- HAZARD_PERF_EN: when defined, adds three ports:
  - stall_cycles  out  32: counts cycles with stall_if=1;
  - flush_events  out  32: counts cycles with flush_ex=1 caused by pc_src_ex;
  - clear_perf  in  1: synchronously zeros both counters, taking priority over increment.
- Both counters wrap at 2^32, reset to 0, and are held at 0 while reset_n=0.
- When HAZARD_PERF_EN is undefined, these ports and counters do not exist and the rest of the behaviour is identical.

## Test plan
- Load-use: mem_read_ex=1, rd_ex=5, rs1_id=5, use_rs1_id=1 → exactly one cycle of stall_if=stall_id=flush_ex=1. Repeat with rd_ex=0 → no stall.
- Redirect plus load-use in the same cycle: pc_src_ex=1, load_use true → flush_id=flush_ex=1, stall_if=0.
- Memory wait: dmem_req_mem=1 with dmem_ready rising 3 cycles later → 3 stall cycles with flush_wb=1, FSM back in RUN, no error. A branch in EX during the wait is flushed only after the wait ends.
- Timeout with MEM_TIMEOUT=4 and dmem_ready held low → 3 stall cycles, release on the 4th cycle, mem_timeout_err=1 and sticky until reset_n=0.
- Forwarding: rd_mem=rd_wb=7, both writing, rs1_ex=7 → forward_a=10. With reg_write_mem=0 → forward_a=01. With rd=0 → 00.
- Reset mid-wait: reset_n=0 in the second wait cycle → all outputs 0 that cycle, next cycle in RUN, wait_cnt=0. With HAZARD_PERF_EN defined, both counters read 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the five-stage RV32 pipeline: load-use bubbles, EX redirects,
// bounded data-memory waits and EX operand forwarding. Define HAZARD_PERF_EN to add perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       use_rs1_id,
  input  logic       use_rs2_id,
  input  logic [4:0] rs1_ex,
  input  logic [4:0] rs2_ex,
  input  logic [4:0] rd_ex,
  input  logic       mem_read_ex,
  input  logic [4:0] rd_mem,
  input  logic       reg_write_mem,
  input  logic [4:0] rd_wb,
  input  logic       reg_write_wb,
  input  logic       pc_src_ex,
  input  logic       dmem_req_mem,
  input  logic       dmem_ready,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       stall_mem,
  output logic       flush_id,
  output logic       flush_ex,
  output logic       flush_wb,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b,
  output logic       mem_timeout_err
`ifdef HAZARD_PERF_EN
  ,
  input  logic        clear_perf,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  localparam logic [7:0] RELEASE_CNT = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic       err_q, err_next;
  logic       mem_release;
  logic       mem_stall;
  logic       load_use;
  logic       redirect_flush;

  always_comb begin
    mem_release = (state == MEM_WAIT) && (wait_cnt == RELEASE_CNT);
    mem_stall   = dmem_req_mem && !dmem_ready && !mem_release;
    load_use    = mem_read_ex && (rd_ex != 5'd0) &&
                  ((use_rs1_id && (rd_ex == rs1_id)) || (use_rs2_id && (rd_ex == rs2_id)));
  end

  // A memory stall freezes EX, so a redirect or load-use there must wait until the stall ends.
  always_comb begin
    stall_if       = 1'b0;
    stall_id       = 1'b0;
    stall_ex       = 1'b0;
    stall_mem      = 1'b0;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    flush_wb       = 1'b0;
    redirect_flush = 1'b0;
    if (reset_n) begin
      if (mem_stall) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        flush_wb  = 1'b1;
      end else if (pc_src_ex) begin
        flush_id       = 1'b1;
        flush_ex       = 1'b1;
        redirect_flush = 1'b1;
      end else if (load_use) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (reg_write_mem && (rd_mem != 5'd0) && (rd_mem == rs)) begin
      return 2'b10;
    end else if (reg_write_wb && (rd_wb != 5'd0) && (rd_wb == rs)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    forward_a       = 2'b00;
    forward_b       = 2'b00;
    mem_timeout_err = 1'b0;
    if (reset_n) begin
      forward_a       = fwd_sel(rs1_ex);
      forward_b       = fwd_sel(rs2_ex);
      mem_timeout_err = err_q;
    end
  end

  // A response arriving on the release cycle is a normal completion, not a timeout.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    err_next      = err_q;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          wait_cnt_next = wait_cnt + 8'd1;
        end else begin
          state_next    = RUN;
          wait_cnt_next = 8'd0;
          if (mem_release && dmem_req_mem && !dmem_ready) begin
            err_next = 1'b1;
          end
        end
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      err_q    <= err_next;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_events_q;

  always_ff @(posedge clk) begin
    if (!reset_n || clear_perf) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_q + {31'd0, stall_if};
      flush_events_q <= flush_events_q + {31'd0, redirect_flush};
    end
  end

  assign stall_cycles = reset_n ? stall_cycles_q : 32'd0;
  assign flush_events = reset_n ? flush_events_q : 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios followed by random
// traffic, all compared every cycle against a stall-length based model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 4;

  logic       clk;
  logic       reset_n;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic       use_rs1_id, use_rs2_id, mem_read_ex, reg_write_mem, reg_write_wb;
  logic       pc_src_ex, dmem_req_mem, dmem_ready;
  logic       stall_if, stall_id, stall_ex, stall_mem;
  logic       flush_id, flush_ex, flush_wb;
  logic [1:0] forward_a, forward_b;
  logic       mem_timeout_err;
`ifdef HAZARD_PERF_EN
  logic        clear_perf;
  logic [31:0] stall_cycles, flush_events;
  logic [31:0] m_stall_cnt;
  logic [31:0] m_flush_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int stall_run    = 0;
  bit m_err        = 1'b0;
  bit exp_mstall;
  bit exp_redirect;
  bit exp_stall_if;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rs1_id         (rs1_id),
    .rs2_id         (rs2_id),
    .use_rs1_id     (use_rs1_id),
    .use_rs2_id     (use_rs2_id),
    .rs1_ex         (rs1_ex),
    .rs2_ex         (rs2_ex),
    .rd_ex          (rd_ex),
    .mem_read_ex    (mem_read_ex),
    .rd_mem         (rd_mem),
    .reg_write_mem  (reg_write_mem),
    .rd_wb          (rd_wb),
    .reg_write_wb   (reg_write_wb),
    .pc_src_ex      (pc_src_ex),
    .dmem_req_mem   (dmem_req_mem),
    .dmem_ready     (dmem_ready),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .stall_ex       (stall_ex),
    .stall_mem      (stall_mem),
    .flush_id       (flush_id),
    .flush_ex       (flush_ex),
    .flush_wb       (flush_wb),
    .forward_a      (forward_a),
    .forward_b      (forward_b),
    .mem_timeout_err(mem_timeout_err)
`ifdef HAZARD_PERF_EN
    ,
    .clear_perf     (clear_perf),
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  function automatic logic [1:0] fwdModel(input logic [4:0] rs);
    if (reg_write_mem && rd_mem != 5'd0 && rd_mem == rs) return 2'b10;
    if (reg_write_wb && rd_wb != 5'd0 && rd_wb == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Model: a memory access may stall for at most TMO-1 consecutive cycles.
  task automatic checkOutput();
    bit         lu;
    logic [6:0] exp_ctrl;
    exp_mstall   = dmem_req_mem && !dmem_ready && (stall_run < TMO - 1);
    lu           = mem_read_ex && rd_ex != 5'd0 &&
                   ((use_rs1_id && rd_ex == rs1_id) || (use_rs2_id && rd_ex == rs2_id));
    exp_redirect = 1'b0;
    exp_ctrl     = 7'b0;
    if (reset_n) begin
      if (exp_mstall) exp_ctrl = 7'b1111001;
      else if (pc_src_ex) begin
        exp_ctrl     = 7'b0000110;
        exp_redirect = 1'b1;
      end else if (lu) exp_ctrl = 7'b1100010;
    end
    exp_stall_if = exp_ctrl[6];
    checkVal("ctrl", 32'({stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb}),
             32'(exp_ctrl));
    checkVal("forward_a", 32'(forward_a), reset_n ? 32'(fwdModel(rs1_ex)) : 32'd0);
    checkVal("forward_b", 32'(forward_b), reset_n ? 32'(fwdModel(rs2_ex)) : 32'd0);
    checkVal("timeout_err", 32'(mem_timeout_err), reset_n ? 32'(m_err) : 32'd0);
`ifdef HAZARD_PERF_EN
    checkVal("stall_cycles", stall_cycles, reset_n ? m_stall_cnt : 32'd0);
    checkVal("flush_events", flush_events, reset_n ? m_flush_cnt : 32'd0);
`endif
  endtask

  task automatic modelStep();
    if (!reset_n) begin
      stall_run = 0;
      m_err     = 1'b0;
    end else begin
      if (dmem_req_mem && !dmem_ready && stall_run == TMO - 1) m_err = 1'b1;
      stall_run = exp_mstall ? stall_run + 1 : 0;
    end
`ifdef HAZARD_PERF_EN
    if (!reset_n || clear_perf) begin
      m_stall_cnt = 32'd0;
      m_flush_cnt = 32'd0;
    end else begin
      m_stall_cnt = m_stall_cnt + 32'(exp_stall_if);
      m_flush_cnt = m_flush_cnt + 32'(exp_redirect);
    end
`endif
  endtask

  task automatic settle();
    #2;
    checkOutput();
  endtask

  task automatic advance();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    {rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb} = '0;
    {use_rs1_id, use_rs2_id, mem_read_ex, reg_write_mem, reg_write_wb} = '0;
    {pc_src_ex, dmem_req_mem, dmem_ready} = '0;
`ifdef HAZARD_PERF_EN
    clear_perf = 1'b0;
`endif
  endtask

  task automatic applyStimulus();
    reset_n       = ($urandom_range(0, 49) != 0);
    rs1_id        = 5'($urandom_range(0, 3));
    rs2_id        = 5'($urandom_range(0, 3));
    rs1_ex        = 5'($urandom_range(0, 3));
    rs2_ex        = 5'($urandom_range(0, 3));
    rd_ex         = 5'($urandom_range(0, 3));
    rd_mem        = 5'($urandom_range(0, 3));
    rd_wb         = 5'($urandom_range(0, 3));
    use_rs1_id    = 1'($urandom_range(0, 1));
    use_rs2_id    = 1'($urandom_range(0, 1));
    mem_read_ex   = ($urandom_range(0, 2) == 0);
    reg_write_mem = 1'($urandom_range(0, 1));
    reg_write_wb  = 1'($urandom_range(0, 1));
    pc_src_ex     = ($urandom_range(0, 5) == 0);
    dmem_req_mem  = ($urandom_range(0, 2) != 0);
    dmem_ready    = ($urandom_range(0, 3) == 0);
`ifdef HAZARD_PERF_EN
    clear_perf    = ($urandom_range(0, 39) == 0);
`endif
  endtask

  initial begin
    int n;
`ifdef HAZARD_PERF_EN
    m_stall_cnt = 32'd0;
    m_flush_cnt = 32'd0;
`endif
    clearInputs();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    settle();
    checkVal("reset_stall_if", 32'(stall_if), 32'd0);
    checkVal("reset_err", 32'(mem_timeout_err), 32'd0);
    advance();
    reset_n = 1'b1;

    // load-use bubble lasts one cycle, and never for x0
    mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; use_rs1_id = 1'b1;
    settle();
    checkVal("lu_stall_if", 32'(stall_if), 32'd1);
    checkVal("lu_flush_ex", 32'(flush_ex), 32'd1);
    checkVal("lu_flush_id", 32'(flush_id), 32'd0);
    advance();
    mem_read_ex = 1'b0;
    settle();
    checkVal("lu_after", 32'(stall_if), 32'd0);
    advance();
    mem_read_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0;
    settle();
    checkVal("lu_x0", 32'(stall_if), 32'd0);
    advance();

    // redirect squashes a simultaneous load-use
    rd_ex = 5'd5; rs1_id = 5'd5; pc_src_ex = 1'b1;
    settle();
    checkVal("redir_flush_id", 32'(flush_id), 32'd1);
    checkVal("redir_flush_ex", 32'(flush_ex), 32'd1);
    checkVal("redir_stall_if", 32'(stall_if), 32'd0);
    advance();
    clearInputs();

    // memory waits of N = 0..2 cycles, with a branch held in EX
    for (int lat = 0; lat < 3; lat++) begin
      n = 0;
      dmem_req_mem = 1'b1; pc_src_ex = 1'b1;
      for (int c = 0; c < lat; c++) begin
        dmem_ready = 1'b0;
        settle();
        n += int'(stall_if);
        checkVal("wait_no_flush_id", 32'(flush_id), 32'd0);
        advance();
      end
      dmem_ready = 1'b1;
      settle();
      checkVal("wait_done_stall", 32'(stall_if), 32'd0);
      checkVal("wait_done_flush_id", 32'(flush_id), 32'd1);
      advance();
      checkVal("wait_stall_count", 32'(n), 32'(lat));
      clearInputs();
      settle();
      checkVal("wait_no_err", 32'(mem_timeout_err), 32'd0);
      advance();
    end

    // timeout: ready never arrives
    n = 0;
    dmem_req_mem = 1'b1;
    for (int c = 0; c < TMO; c++) begin
      settle();
      n += int'(stall_if);
      advance();
    end
    checkVal("tmo_stall_count", 32'(n), 32'(TMO - 1));
    dmem_req_mem = 1'b0;
    for (int c = 0; c < 2; c++) begin
      settle();
      checkVal("tmo_err_sticky", 32'(mem_timeout_err), 32'd1);
      advance();
    end
    reset_n = 1'b0;
    settle();
    advance();
    reset_n = 1'b1;
    settle();
    checkVal("tmo_err_cleared", 32'(mem_timeout_err), 32'd0);
    advance();

    // forwarding priority
    rd_mem = 5'd7; rd_wb = 5'd7; reg_write_mem = 1'b1; reg_write_wb = 1'b1; rs1_ex = 5'd7;
    settle();
    checkVal("fwd_mem", 32'(forward_a), 32'd2);
    advance();
    reg_write_mem = 1'b0;
    settle();
    checkVal("fwd_wb", 32'(forward_a), 32'd1);
    advance();
    rd_mem = 5'd0; rd_wb = 5'd0; reg_write_mem = 1'b1;
    settle();
    checkVal("fwd_x0", 32'(forward_a), 32'd0);
    advance();

    // reset in the second wait cycle aborts the wait
    rd_mem = 5'd7; rs1_ex = 5'd7;
    dmem_req_mem = 1'b1;
    settle();
    advance();
    reset_n = 1'b0;
    settle();
    checkVal("rstwait_stall", 32'(stall_if), 32'd0);
    checkVal("rstwait_flush_wb", 32'(flush_wb), 32'd0);
    checkVal("rstwait_fwd", 32'(forward_a), 32'd0);
    advance();
    reset_n = 1'b1;
    n = 0;
    for (int c = 0; c < TMO; c++) begin
      settle();
      n += int'(stall_if);
      advance();
    end
    checkVal("rstwait_restart", 32'(n), 32'(TMO - 1));
    clearInputs();

    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      settle();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
